// File: rtl/maxpool_row_feeder_if.sv
// Interface for the max-pool row feeder: configuration/start, row-RAM read port and downstream row port.
// The slave modport is the feeder's view; master is the host/memory/downstream side.
interface maxpool_row_feeder_if #(
  parameter int IMG_WIDTH  = 32,
  parameter int TIME_STEPS = 4,
  parameter int ADDR_W     = 16
);
  localparam int DW = IMG_WIDTH * TIME_STEPS;

  logic              code_valid;
  logic [15:0]       conv_in_ch;
  logic [15:0]       conv_img_size;
  logic              i_start;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DW-1:0]     i_rd_data;
  logic              i_calculating_flag;
  logic              o_row_data_valid;
  logic [DW-1:0]     o_row_data;
  logic              o_busy;
  logic              o_done;
  logic              o_cfg_err;

  modport master (
    output code_valid, conv_in_ch, conv_img_size, i_start, i_rd_data, i_calculating_flag,
    input  o_rd_en, o_rd_addr, o_row_data_valid, o_row_data, o_busy, o_done, o_cfg_err
  );

  modport slave (
    input  code_valid, conv_in_ch, conv_img_size, i_start, i_rd_data, i_calculating_flag,
    output o_rd_en, o_rd_addr, o_row_data_valid, o_row_data, o_busy, o_done, o_cfg_err
  );
endinterface

// File: rtl/maxpool_row_feeder.sv
// Reads spike-map rows from row RAM, optionally ORs vertical neighbours, and feeds one row at a time downstream.
// Define MAXPOOL_VERTICAL_POOL_EN to OR source rows 2j-1..2j+1 into output row j (size/2 rows per channel).
//
// state   | meaning
// IDLE    | waiting for config strobe or start
// READ    | issuing back-to-back row reads for the current output row
// DRAIN   | capturing the last read return
// WAIT_DS | holding the finished row until downstream is not busy
// SEND    | one-cycle row pulse to downstream
// GUARD   | two cycles covering downstream busy-flag rise latency
// DONE    | one-cycle frame-complete pulse
module maxpool_row_feeder #(
  parameter int IMG_WIDTH  = 32,
  parameter int TIME_STEPS = 4,
  parameter int ADDR_W     = 16
) (
  input logic                  s_clk,
  input logic                  s_rst,
  maxpool_row_feeder_if.slave  bus
);
  localparam int DW = IMG_WIDTH * TIME_STEPS;
  localparam logic [1:0] GUARD_CYCLES = 2'd2;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, GUARD, WAIT_DS, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       cfg_ch, cfg_size;
  logic [15:0]       ch_cnt, row_cnt, rd_src;
  logic [1:0]        rd_left, guard_cnt;
  logic [ADDR_W-1:0] base_addr;
  logic [DW-1:0]     acc, row_data;
  logic              rd_pend, cfg_err;
  logic              rd_en, row_valid, busy, done;
  logic              cfg_ok, last_row, last_ch;
  logic [15:0]       rows_per_ch, first_src;
  logic [1:0]        first_left;

  assign cfg_ok   = (cfg_size[0] == 1'b0) && (cfg_size >= 16'd4) && (cfg_ch != 16'd0);
  assign last_row = (row_cnt == rows_per_ch - 16'd1);
  assign last_ch  = (ch_cnt == cfg_ch - 16'd1);

`ifdef MAXPOOL_VERTICAL_POOL_EN
  // Row 0 has no row above it, so it needs only two reads starting at source row 0.
  assign rows_per_ch = {1'b0, cfg_size[15:1]};
  assign first_src   = (row_cnt == 16'd0) ? 16'd0 : ({row_cnt[14:0], 1'b0} - 16'd1);
  assign first_left  = (row_cnt == 16'd0) ? 2'd1 : 2'd2;
`else
  assign rows_per_ch = cfg_size;
  assign first_src   = row_cnt;
  assign first_left  = 2'd0;
`endif

  always_ff @(posedge s_clk) begin
    if (!s_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    row_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.i_start && cfg_ok) state_nxt = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_left == 2'd0) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = WAIT_DS;
      WAIT_DS: if (!bus.i_calculating_flag) state_nxt = SEND;
      SEND: begin
        row_valid = 1'b1;
        state_nxt = (last_row && last_ch) ? DONE : GUARD;
      end
      GUARD:   if (guard_cnt == 2'd0) state_nxt = READ;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      cfg_ch    <= '0;
      cfg_size  <= '0;
      ch_cnt    <= '0;
      row_cnt   <= '0;
      rd_src    <= '0;
      rd_left   <= '0;
      guard_cnt <= '0;
      base_addr <= '0;
      acc       <= '0;
      row_data  <= '0;
      rd_pend   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (state == IDLE && bus.code_valid) begin
        cfg_ch   <= bus.conv_in_ch;
        cfg_size <= bus.conv_img_size;
      end
      cfg_err <= (state == IDLE) && bus.i_start && !cfg_ok;
      rd_pend <= (state == READ);

      if (state_nxt == READ && state != READ) begin
        acc     <= '0;
        rd_src  <= first_src;
        rd_left <= first_left;
      end else begin
        if (rd_pend) acc <= acc | bus.i_rd_data;
        if (state == READ) begin
          rd_src <= rd_src + 16'd1;
          if (rd_left != 2'd0) rd_left <= rd_left - 2'd1;
        end
      end

      if (state == WAIT_DS && state_nxt == SEND) row_data <= acc;

      // Counters wrap back to zero after the final row so IDLE always starts at channel 0, row 0.
      if (state == SEND) begin
        guard_cnt <= GUARD_CYCLES - 2'd1;
        if (last_row) begin
          row_cnt <= '0;
          if (last_ch) begin
            ch_cnt    <= '0;
            base_addr <= '0;
          end else begin
            ch_cnt    <= ch_cnt + 16'd1;
            base_addr <= base_addr + ADDR_W'(cfg_size);
          end
        end else begin
          row_cnt <= row_cnt + 16'd1;
        end
      end else if (state == GUARD && guard_cnt != 2'd0) begin
        guard_cnt <= guard_cnt - 2'd1;
      end
    end
  end

  assign bus.o_rd_en          = rd_en;
  assign bus.o_rd_addr        = base_addr + ADDR_W'(rd_src);
  assign bus.o_row_data_valid = row_valid;
  assign bus.o_row_data       = row_data;
  assign bus.o_busy           = busy;
  assign bus.o_done           = done;
  assign bus.o_cfg_err        = cfg_err;
endmodule
